// File: rtl/ddr_refresh_ctrl.sv
// DDR refresh controller: counts owed refreshes from the 7.8 us tick and, once granted
// the command bus, issues PRECHARGE ALL followed by one or more AUTO REFRESH commands.
module ddr_refresh_ctrl #(
    parameter int trp_cyc       = 2,
    parameter int trfc_cyc      = 5,
    parameter int max_pending   = 8,
    parameter int urgent_thresh = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pulse78,
    output logic       ref_req,
    input  logic       ref_gnt,
    output logic       ref_busy,
    output logic       ref_urgent,
    output logic       ref_cmd_valid,
    output logic [1:0] ref_cmd,
    output logic [3:0] pending,
    output logic       overflow
);

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_PREA  = 2'b01;
    localparam logic [1:0] CMD_AREF  = 2'b10;
    localparam logic [3:0] MAX_PEND  = 4'(max_pending);
    localparam logic [3:0] URG_LEVEL = 4'(urgent_thresh);
    localparam logic [7:0] TRP_LOAD  = 8'(trp_cyc - 1);
    localparam logic [7:0] TRFC_LOAD = 8'(trfc_cyc - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        PRECH,
        WAIT_RP,
        AREF,
        WAIT_RFC
    } state_t;

    state_t     state;
    logic [7:0] wait_cnt;
    logic       aref_issue;
    logic [3:0] pending_next;
    logic       overflow_set;

    // The AUTO REFRESH command is on the bus during the AREF state, so that edge retires one.
    assign aref_issue = (state == AREF);

    always_comb begin
        pending_next = pending;
        overflow_set = 1'b0;
        if (pulse78 && !aref_issue) begin
            if (pending == MAX_PEND) begin
                overflow_set = 1'b1;
            end else begin
                pending_next = pending + 4'd1;
            end
        end else if (aref_issue && !pulse78 && (pending != 4'd0)) begin
            pending_next = pending - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending    <= 4'd0;
            overflow   <= 1'b0;
            ref_urgent <= 1'b0;
        end else begin
            pending    <= pending_next;
            ref_urgent <= (pending_next >= URG_LEVEL);
            if (overflow_set) begin
                overflow <= 1'b1;
            end
        end
    end

    // Outputs are loaded together with the state they belong to, so they are valid
    // in the very cycle that state is occupied.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            ref_req       <= 1'b0;
            ref_busy      <= 1'b0;
            ref_cmd_valid <= 1'b0;
            ref_cmd       <= CMD_NOP;
        end else begin
            ref_cmd_valid <= 1'b0;
            ref_cmd       <= CMD_NOP;
            case (state)
                IDLE: begin
                    if (pending != 4'd0) begin
                        state   <= REQ;
                        ref_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (ref_gnt) begin
                        state         <= PRECH;
                        ref_req       <= 1'b0;
                        ref_busy      <= 1'b1;
                        ref_cmd_valid <= 1'b1;
                        ref_cmd       <= CMD_PREA;
                    end
                end
                PRECH: begin
                    state    <= WAIT_RP;
                    wait_cnt <= TRP_LOAD;
                end
                WAIT_RP: begin
                    if (wait_cnt == 8'd0) begin
                        state         <= AREF;
                        ref_cmd_valid <= 1'b1;
                        ref_cmd       <= CMD_AREF;
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                AREF: begin
                    state    <= WAIT_RFC;
                    wait_cnt <= TRFC_LOAD;
                end
                WAIT_RFC: begin
                    // Banks are still precharged, so a deep backlog chains straight into another refresh.
                    if (wait_cnt == 8'd0) begin
                        if (pending >= URG_LEVEL) begin
                            state         <= AREF;
                            ref_cmd_valid <= 1'b1;
                            ref_cmd       <= CMD_AREF;
                        end else begin
                            state    <= IDLE;
                            ref_busy <= 1'b0;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ref_req  <= 1'b0;
                    ref_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
